// File: rtl/pipo_reg_bank.sv
// pipo_reg_bank: DEPTH x N register bank with one in-place-op
// write port, two combinational read ports and a carry flag.
module pipo_reg_bank #(
    parameter  int N     = 4,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          Clock,
    input  logic          Clear,
    input  logic          WE,
    input  logic [AW-1:0] WA,
    input  logic [2:0]    Op,
    input  logic [N-1:0]  D,
    input  logic          SI,
    input  logic [AW-1:0] RA,
    input  logic [AW-1:0] RB,
    output logic [N-1:0]  QA,
    output logic [N-1:0]  QB,
    output logic          CO
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_CLR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_SHR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_INC  = 3'b110,
        OP_DEC  = 3'b111
    } op_e;

    localparam logic [N:0] ONE = (N+1)'(1);

    logic [N-1:0] r_q [DEPTH];
    logic         co_q;
    logic [N-1:0] r_d;
    logic         co_d;
    logic         wr;
    logic [N-1:0] cur;
    logic [N:0]   sum;
    logic         wa_ok;
    logic         ra_ok;
    logic         rb_ok;
    op_e          op;

    assign op = op_e'(Op);

    // Addresses beyond DEPTH exist only for non-power-of-2 banks.
    if (DEPTH == (1 << AW)) begin : g_pow2
        assign wa_ok = 1'b1;
        assign ra_ok = 1'b1;
        assign rb_ok = 1'b1;
    end else begin : g_npow2
        assign wa_ok = (32'(WA) < DEPTH);
        assign ra_ok = (32'(RA) < DEPTH);
        assign rb_ok = (32'(RB) < DEPTH);
    end

    // Old value of the addressed register (0 when out of range).
    always_comb begin
        cur = '0;
        if (wa_ok) cur = r_q[WA];
    end

    // Next value of the addressed register and of the carry flag.
    always_comb begin
        r_d  = cur;
        co_d = co_q;
        wr   = 1'b0;
        sum  = '0;
        if (WE && wa_ok) begin
            wr = 1'b1;
            unique case (op)
                OP_HOLD: wr = 1'b0;
                OP_LOAD: begin
                    r_d  = D;
                    co_d = 1'b0;
                end
                OP_CLR: begin
                    r_d  = '0;
                    co_d = 1'b0;
                end
                OP_SHL: begin
                    r_d  = {cur[N-2:0], SI};
                    co_d = cur[N-1];
                end
                OP_SHR: begin
                    r_d  = {SI, cur[N-1:1]};
                    co_d = cur[0];
                end
                OP_ROL: begin
                    r_d  = {cur[N-2:0], cur[N-1]};
                    co_d = cur[N-1];
                end
                OP_INC: begin
                    sum  = {1'b0, cur} + ONE;
                    r_d  = sum[N-1:0];
                    co_d = sum[N];
                end
                OP_DEC: begin
                    sum  = {1'b0, cur} - ONE;
                    r_d  = sum[N-1:0];
                    co_d = sum[N];
                end
                default: wr = 1'b0;
            endcase
        end
    end

    // State updates on the falling edge; Clear wipes everything at once.
    always_ff @(negedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
            co_q <= 1'b0;
        end else begin
            if (wr) r_q[WA] <= r_d;
            co_q <= co_d;
        end
    end

    assign QA = ra_ok ? r_q[RA] : '0;
    assign QB = rb_ok ? r_q[RB] : '0;
    assign CO = co_q;

endmodule
